// File: rtl/alu_flag_commit.sv
// Commit stage behind the ALU: evaluates the ARM condition field against the
// owned NZCV flags, conditionally updates them, and buffers one write-back entry.
module alu_flag_commit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   in_cond,
    input  logic         in_set_flags,
    input  logic [3:0]   in_rd,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_nzcv,
    input  logic         alu_writeback,
    output logic [3:0]   nzcv_old,
    input  logic         flush,
    output logic         wb_valid,
    input  logic         wb_ready,
    output logic [3:0]   wb_rd,
    output logic [N-1:0] wb_data,
    output logic [15:0]  skip_cnt
);

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    logic [3:0]   r_flags;
    logic         r_wb_valid;
    logic [3:0]   r_wb_rd;
    logic [N-1:0] r_wb_data;
    logic [15:0]  r_skip_cnt;

    logic  w_n, w_z, w_c, w_v;
    logic  w_cond_pass;
    logic  w_accept;
    logic  w_commit;
    logic  w_skip;
    logic  w_wb_load;
    cond_e w_cond;

    assign w_n    = r_flags[3];
    assign w_z    = r_flags[2];
    assign w_c    = r_flags[1];
    assign w_v    = r_flags[0];
    assign w_cond = cond_e'(in_cond);

    // Evaluated against the flags as they stand before the edge.
    always_comb begin
        w_cond_pass = 1'b0;
        case (w_cond)
            COND_EQ: w_cond_pass = w_z;
            COND_NE: w_cond_pass = !w_z;
            COND_CS: w_cond_pass = w_c;
            COND_CC: w_cond_pass = !w_c;
            COND_MI: w_cond_pass = w_n;
            COND_PL: w_cond_pass = !w_n;
            COND_VS: w_cond_pass = w_v;
            COND_VC: w_cond_pass = !w_v;
            COND_HI: w_cond_pass = w_c && !w_z;
            COND_LS: w_cond_pass = !w_c || w_z;
            COND_GE: w_cond_pass = (w_n == w_v);
            COND_LT: w_cond_pass = (w_n != w_v);
            COND_GT: w_cond_pass = !w_z && (w_n == w_v);
            COND_LE: w_cond_pass = w_z || (w_n != w_v);
            COND_AL: w_cond_pass = 1'b1;
            COND_NV: w_cond_pass = 1'b0;
            default: w_cond_pass = 1'b0;
        endcase
    end

    assign in_ready  = !flush && (!r_wb_valid || wb_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_commit  = w_accept && w_cond_pass;
    assign w_skip    = w_accept && !w_cond_pass;
    assign w_wb_load = w_commit && alu_writeback;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_commit && in_set_flags) begin
            r_flags <= alu_nzcv;
        end
    end

    // Accepting implies the old entry is empty or draining, so a non-loading
    // accept may simply fall through to the drain branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
        end else if (flush) begin
            r_wb_valid <= 1'b0;
        end else if (w_wb_load) begin
            r_wb_valid <= 1'b1;
            r_wb_rd    <= in_rd;
            r_wb_data  <= alu_result;
        end else if (wb_ready) begin
            r_wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_cnt <= '0;
        end else if (w_skip && (r_skip_cnt != '1)) begin
            r_skip_cnt <= r_skip_cnt + 16'd1;
        end
    end

    assign nzcv_old = r_flags;
    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign skip_cnt = r_skip_cnt;

endmodule

// File: tb/tb_alu_flag_commit.sv
// Self-checking bench for alu_flag_commit: condition-table sweep, directed
// corner sequences, randomized traffic against a behavioural model.
module tb_alu_flag_commit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond;
    logic        in_set_flags;
    logic [3:0]  in_rd;
    logic [31:0] alu_result;
    logic [3:0]  alu_nzcv;
    logic        alu_writeback;
    logic [3:0]  nzcv_old;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [15:0] skip_cnt;

    always #5 clk = ~clk;

    alu_flag_commit #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_set_flags(in_set_flags), .in_rd(in_rd),
        .alu_result(alu_result), .alu_nzcv(alu_nzcv), .alu_writeback(alu_writeback),
        .nzcv_old(nzcv_old), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .skip_cnt(skip_cnt)
    );

    typedef struct {
        logic [3:0]  cond;
        logic [15:0] pass_mask;  // bit f set = passes with flags f
    } cond_vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [3:0]  m_flags;
    logic        m_wbv;
    logic [3:0]  m_rd;
    logic [31:0] m_data;
    int          m_skip;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ARM decomposition: even codes test a base predicate, odd codes its inverse.
    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'd15) return 1'b0;
        if (c == 4'd14) return 1'b1;
        return base ^ c[0];
    endfunction

    task automatic model_reset();
        m_flags = '0; m_wbv = 1'b0; m_rd = '0; m_data = '0; m_skip = 0;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_cond = 4'd14; in_set_flags = 1'b0; in_rd = '0;
        alu_result = '0; alu_nzcv = '0; alu_writeback = 1'b0; flush = 1'b0;
        wb_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock with the currently driven inputs; entered and left at negedge.
    task automatic step();
        bit rdy, acc, pass, loaded, drained;
        logic [3:0]  s_rd, s_nzcv;
        logic [31:0] s_res;
        bit s_flush, s_set, s_wbk, s_rdy_in;
        #1;
        rdy = !flush && (!m_wbv || wb_ready);
        chk("in_ready", in_ready, rdy);
        acc = in_valid && rdy;
        pass = m_cond(in_cond, m_flags);
        s_rd = in_rd; s_nzcv = alu_nzcv; s_res = alu_result;
        s_flush = flush; s_set = in_set_flags; s_wbk = alu_writeback; s_rdy_in = wb_ready;
        @(posedge clk);
        #1;
        loaded  = acc && pass && s_wbk;
        drained = m_wbv && s_rdy_in;
        m_wbv   = !s_flush && (loaded || (m_wbv && !drained));
        if (loaded && !s_flush) begin m_rd = s_rd; m_data = s_res; end
        if (acc && pass && s_set) m_flags = s_nzcv;
        if (acc && !pass) m_skip = (m_skip >= 65535) ? 65535 : m_skip + 1;
        chk("nzcv_old", nzcv_old, m_flags);
        chk("wb_valid", wb_valid, m_wbv);
        chk("wb_rd", wb_rd, m_rd);
        chk("wb_data", wb_data, m_data);
        chk("skip_cnt", skip_cnt, m_skip[15:0]);
        @(negedge clk);
    endtask

    task automatic op(input logic [3:0] c, input bit s, input bit wbk,
                      input logic [3:0] rd, input logic [31:0] res, input logic [3:0] nz);
        in_valid = 1'b1; in_cond = c; in_set_flags = s; alu_writeback = wbk;
        in_rd = rd; alu_result = res; alu_nzcv = nz;
        step();
    endtask

    cond_vec_t vecs[16];
    logic [3:0] saved_flags;
    logic [15:0] mask;

    initial begin
        vecs[0]  = '{4'd0,  16'hF0F0};  // EQ
        vecs[1]  = '{4'd1,  16'h0F0F};  // NE
        vecs[2]  = '{4'd2,  16'hCCCC};  // CS
        vecs[3]  = '{4'd3,  16'h3333};  // CC
        vecs[4]  = '{4'd4,  16'hFF00};  // MI
        vecs[5]  = '{4'd5,  16'h00FF};  // PL
        vecs[6]  = '{4'd6,  16'hAAAA};  // VS
        vecs[7]  = '{4'd7,  16'h5555};  // VC
        vecs[8]  = '{4'd8,  16'h0C0C};  // HI
        vecs[9]  = '{4'd9,  16'hF3F3};  // LS
        vecs[10] = '{4'd10, 16'hAA55};  // GE
        vecs[11] = '{4'd11, 16'h55AA};  // LT
        vecs[12] = '{4'd12, 16'h0A05};  // GT
        vecs[13] = '{4'd13, 16'hF5FA};  // LE
        vecs[14] = '{4'd14, 16'hFFFF};  // AL
        vecs[15] = '{4'd15, 16'h0000};  // NV

        rst_n = 1'b1;
        idle_inputs();
        model_reset();
        do_reset();
        #1;
        chk("reset_nzcv", nzcv_old, 4'h0);
        chk("reset_wb_valid", wb_valid, 1'b0);
        chk("reset_wb_data", wb_data, 32'h0);
        chk("reset_skip", skip_cnt, 16'h0);
        @(negedge clk);

        // CMP sets flags, no write-back
        op(4'd14, 1'b1, 1'b0, 4'd1, 32'h0, 4'b0110);
        chk("cmp_flags", nzcv_old, 4'b0110);
        chk("cmp_no_wb", wb_valid, 1'b0);

        // Z=1: EQ passes, NE skipped
        op(4'd14, 1'b1, 1'b0, 4'd0, 32'h0, 4'b0100);
        op(4'd0, 1'b0, 1'b1, 4'd3, 32'h0000_0005, 4'b0000);
        chk("eq_wb_valid", wb_valid, 1'b1);
        chk("eq_wb_rd", wb_rd, 4'd3);
        chk("eq_wb_data", wb_data, 32'h5);
        op(4'd1, 1'b0, 1'b1, 4'd4, 32'h0000_0009, 4'b0000);
        chk("ne_wb_valid", wb_valid, 1'b0);
        chk("ne_wb_rd_held", wb_rd, 4'd3);
        chk("ne_skip", skip_cnt, 16'd1);

        // Backpressure: entry holds for 3 cycles, then drain + reload together
        wb_ready = 1'b0;
        op(4'd14, 1'b0, 1'b1, 4'd2, 32'hDEAD_BEEF, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            op(4'd14, 1'b0, 1'b1, 4'd9, 32'h1111_1111, 4'b0000);
            chk("stall_valid", wb_valid, 1'b1);
            chk("stall_rd", wb_rd, 4'd2);
            chk("stall_data", wb_data, 32'hDEAD_BEEF);
        end
        #1 chk("stall_in_ready", in_ready, 1'b0);
        wb_ready = 1'b1;
        op(4'd14, 1'b0, 1'b1, 4'd7, 32'h0000_0077, 4'b0000);
        chk("reload_valid", wb_valid, 1'b1);
        chk("reload_rd", wb_rd, 4'd7);

        // Flush beats wb_ready and blocks the flag update
        wb_ready = 1'b0;
        op(4'd14, 1'b0, 1'b1, 4'd5, 32'h5555_5555, 4'b0000);
        saved_flags = nzcv_old;
        flush = 1'b1; wb_ready = 1'b1;
        op(4'd14, 1'b1, 1'b1, 4'd6, 32'h6666_6666, 4'b1111);
        chk("flush_valid", wb_valid, 1'b0);
        chk("flush_flags", nzcv_old, saved_flags);
        flush = 1'b0;

        // Asynchronous reset mid-stall
        wb_ready = 1'b0;
        op(4'd14, 1'b1, 1'b1, 4'd8, 32'hCAFE_F00D, 4'b1010);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_valid", wb_valid, 1'b0);
        chk("areset_rd", wb_rd, 4'd0);
        chk("areset_data", wb_data, 32'h0);
        chk("areset_flags", nzcv_old, 4'h0);
        chk("areset_skip", skip_cnt, 16'h0);
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Condition table sweep over every flag value
        for (int v = 0; v < 16; v++) begin
            mask = vecs[v].pass_mask;
            for (int f = 0; f < 16; f++) begin
                op(4'd14, 1'b1, 1'b0, 4'd0, 32'h0, 4'(f));
                op(vecs[v].cond, 1'b0, 1'b1, vecs[v].cond, {24'h0, vecs[v].cond, 4'(f)}, 4'h0);
                chk($sformatf("cond%0d_f%0h", v, f), wb_valid, mask[f]);
            end
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid      = ($urandom_range(0, 9) < 8);
            in_cond       = 4'($urandom_range(0, 15));
            in_set_flags  = $urandom_range(0, 1) == 1;
            alu_writeback = ($urandom_range(0, 3) != 0);
            in_rd         = 4'($urandom_range(0, 15));
            alu_result    = $urandom;
            alu_nzcv      = 4'($urandom_range(0, 15));
            wb_ready      = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 9) == 0);
            step();
        end
        idle_inputs();
        @(negedge clk);

        // Skip counter saturation
        do_reset();
        in_valid = 1'b1; in_cond = 4'd15; alu_writeback = 1'b1;
        repeat (65534) @(posedge clk);
        #1 chk("skip_fffe", skip_cnt, 16'hFFFE);
        repeat (6) @(posedge clk);
        #1 chk("skip_sat", skip_cnt, 16'hFFFF);
        chk("skip_no_wb", wb_valid, 1'b0);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
